// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: oldest-first ready-entry selector that issues one reservation-station entry per cycle to the ALU.
module alu_issue_arbiter #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               clr,
    input  logic               alloc_enable,
    input  logic [IDX_W-1:0]   alloc_idx,
    input  logic [RS_SIZE-1:0] ready_vec,
    input  logic               issue_allow,
    output logic               issue_enable,
    output logic [IDX_W-1:0]   issue_idx,
    output logic [RS_SIZE-1:0] issue_grant,
    output logic [RS_SIZE-1:0] occupied_vec,
    output logic [IDX_W-1:0]   free_idx,
    output logic               full
);
    logic [RS_SIZE-1:0] valid, valid_nxt, cand, blk, win, alloc_oh;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older, older_nxt;
    logic [IDX_W-1:0] win_idx;
    logic fire;
    // an entry wins when no other candidate is older than it
    always_comb begin
        cand = valid & ready_vec;
        blk = '0;
        win_idx = '0;
        for (int w = 0; w < RS_SIZE; w++) begin
            for (int j = 0; j < RS_SIZE; j++)
                if (j != w && cand[j] && older[j][w]) blk[w] = 1'b1;
            if (cand[w] && !blk[w]) win_idx = IDX_W'(w);
        end
        win = cand & ~blk;
        fire = issue_allow & |cand;
        alloc_oh = alloc_enable ? (RS_SIZE'(1) << alloc_idx) : '0;
        valid_nxt = (valid & ~(fire ? win : '0)) | alloc_oh;
    end
    // a new entry is younger than every entry resident at allocation time
    always_comb begin
        older_nxt = older;
        if (alloc_enable) begin
            older_nxt[alloc_idx] = '0;
            for (int j = 0; j < RS_SIZE; j++)
                older_nxt[j][alloc_idx] = (j != int'(alloc_idx)) && valid[j];
        end
    end
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!valid[i]) free_idx = IDX_W'(i);
        full = &valid;
        occupied_vec = valid;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            older <= '0;
            issue_enable <= 1'b0;
            issue_idx <= '0;
            issue_grant <= '0;
        end else if (clr) begin
            valid <= '0;
            older <= '0;
            issue_enable <= 1'b0;
            issue_idx <= '0;
            issue_grant <= '0;
        end else if (rdy) begin
            valid <= valid_nxt;
            older <= older_nxt;
            issue_enable <= fire;
            issue_idx <= fire ? win_idx : issue_idx;
            issue_grant <= fire ? win : '0;
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed and randomized checks against an allocation-order queue model.
module tb_alu_issue_arbiter;
    logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, clr = 1'b0, alloc_enable = 1'b0, issue_allow = 1'b1;
    logic [3:0] alloc_idx = '0;
    logic [15:0] ready_vec = '0;
    logic issue_enable, full;
    logic [3:0] issue_idx, free_idx;
    logic [15:0] issue_grant, occupied_vec;
    int tests = 0, fails = 0;
    int q[$];
    logic m_en;
    logic [3:0] m_idx;
    logic [15:0] m_grant;

    alu_issue_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .alloc_enable(alloc_enable),
        .alloc_idx(alloc_idx), .ready_vec(ready_vec), .issue_allow(issue_allow),
        .issue_enable(issue_enable), .issue_idx(issue_idx), .issue_grant(issue_grant),
        .occupied_vec(occupied_vec), .free_idx(free_idx), .full(full)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] act_vec();
        return {issue_enable, issue_idx, issue_grant, occupied_vec, free_idx, full};
    endfunction

    function automatic logic [41:0] exp_vec();
        logic [15:0] occ = '0;
        logic [3:0] fr = '0;
        bit found = 0;
        foreach (q[i]) occ[q[i]] = 1'b1;
        for (int i = 0; i < 16; i++)
            if (!found && !occ[i]) begin fr = 4'(i); found = 1; end
        return {m_en, m_idx, m_grant, occ, fr, &occ};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_en = 0; m_idx = '0; m_grant = '0;
    endfunction

    // the model advances from the current inputs, then the clock edge happens
    task automatic step();
        int w = -1, pos = 0;
        if (rst && rdy && !clr && alloc_enable)
            assert (!occupied_vec[alloc_idx]) else $error("alloc to occupied slot %0d", alloc_idx);
        if (clr) model_reset();
        else if (rdy) begin
            foreach (q[i]) if (w < 0 && ready_vec[q[i]]) begin w = q[i]; pos = i; end
            if (issue_allow && w >= 0) begin
                m_en = 1; m_idx = 4'(w); m_grant = 16'(1) << w; q.delete(pos);
            end else begin
                m_en = 0; m_grant = '0;
            end
            if (alloc_enable) q.push_back(int'(alloc_idx));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_enable = 0; ready_vec = '0; clr = 0; rdy = 1; issue_allow = 1;
    endtask

    task automatic do_alloc(input int k);
        alloc_enable = 1; alloc_idx = 4'(k);
        step();
        alloc_enable = 0;
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (act_vec() !== 42'h0) begin fails++; $display("FAIL reset_initial: got %h want 0", act_vec()); end
        model_reset();
        @(negedge clk) rst = 1;
        for (int k = 1; k <= 4; k++) do_alloc(k);
        ready_vec = 16'h0002;
        step();
        tests++;
        if (act_vec() !== exp_vec() || !issue_enable || occupied_vec !== 16'h001c) begin
            fails++; $display("FAIL reset_setup: got %h want %h", act_vec(), exp_vec());
        end
        #2 rst = 0;
        #1;
        tests++;
        if (act_vec() !== 42'h0) begin fails++; $display("FAIL reset_async: got %h want 0", act_vec()); end
        model_reset();
        idle();
        @(negedge clk) rst = 1;
        step();
        tests++;
        if (full !== 1'b0 || free_idx !== 4'd0 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_age_order();
        int seq[3] = '{5, 2, 9};
        idle();
        foreach (seq[i]) do_alloc(seq[i]);
        ready_vec = 16'h0224;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (!issue_enable || issue_idx !== 4'(seq[i]) || issue_grant !== (16'(1) << seq[i]) || act_vec() !== exp_vec()) begin
                fails++; $display("FAIL age_order[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        idle();
        step();
    endtask

    task automatic test_ready_override();
        idle();
        do_alloc(3);
        do_alloc(7);
        ready_vec = 16'h0080;
        step();
        tests++;
        if (!issue_enable || issue_idx !== 4'd7 || issue_grant !== 16'h0080 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL ready_override_7: got %h want %h", act_vec(), exp_vec());
        end
        ready_vec = 16'h0088;
        step();
        tests++;
        if (!issue_enable || issue_idx !== 4'd3 || issue_grant !== 16'h0008 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL ready_override_3: got %h want %h", act_vec(), exp_vec());
        end
        step();
        tests++;
        if (issue_enable || issue_grant !== 16'h0 || occupied_vec !== 16'h0 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL ready_no_regrant: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_full_free();
        idle();
        for (int k = 0; k < 16; k++) do_alloc(k);
        tests++;
        if (full !== 1'b1 || free_idx !== 4'd0 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL full_all: got %h want %h", act_vec(), exp_vec());
        end
        ready_vec = 16'h0001;
        step();
        tests++;
        if (full !== 1'b0 || free_idx !== 4'd0 || issue_idx !== 4'd0 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL free_after_0: got %h want %h", act_vec(), exp_vec());
        end
        ready_vec = 16'h0010;
        step();
        tests++;
        if (free_idx !== 4'd0 || occupied_vec !== 16'hffee || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL free_after_4: got %h want %h", act_vec(), exp_vec());
        end
        ready_vec = 16'hffff;
        for (int i = 0; i < 15; i++) begin
            step();
            tests++;
            if (act_vec() !== exp_vec()) begin fails++; $display("FAIL drain[%0d]: got %h want %h", i, act_vec(), exp_vec()); end
        end
    endtask

    task automatic test_stall();
        idle();
        do_alloc(6);
        do_alloc(11);
        ready_vec = 16'h0840;
        step();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (!issue_enable || issue_idx !== 4'd6 || occupied_vec !== 16'h0800 || act_vec() !== exp_vec()) begin
                fails++; $display("FAIL stall[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        rdy = 1;
        step();
        tests++;
        if (!issue_enable || issue_idx !== 4'd11 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL stall_resume: got %h want %h", act_vec(), exp_vec());
        end
        idle();
        do_alloc(1);
        ready_vec = 16'h0002;
        issue_allow = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (issue_enable || issue_grant !== 16'h0 || occupied_vec !== 16'h0002 || act_vec() !== exp_vec()) begin
                fails++; $display("FAIL allow_low[%0d]: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        issue_allow = 1;
        step();
        tests++;
        if (!issue_enable || issue_idx !== 4'd1 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL allow_high: got %h want %h", act_vec(), exp_vec());
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        idle();
        for (int k = 0; k < 4; k++) do_alloc(k);
        ready_vec = 16'h0001;
        clr = 1;
        alloc_enable = 1;
        alloc_idx = 4'd8;
        step();
        idle();
        tests++;
        if (occupied_vec !== 16'h0 || issue_enable || issue_idx !== 4'd0 || act_vec() !== exp_vec()) begin
            fails++; $display("FAIL flush: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int fr[$];
        logic [15:0] occ;
        for (int c = 0; c < 400; c++) begin
            occ = '0;
            foreach (q[i]) occ[q[i]] = 1'b1;
            fr.delete();
            for (int i = 0; i < 16; i++) if (!occ[i]) fr.push_back(i);
            alloc_enable = (fr.size() > 0) && ($urandom_range(0, 3) != 0);
            alloc_idx = fr.size() > 0 ? 4'(fr[$urandom_range(0, fr.size() - 1)]) : 4'd0;
            ready_vec = 16'($urandom);
            issue_allow = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 9) != 0;
            clr = $urandom_range(0, 49) == 0;
            step();
            tests++;
            if (act_vec() !== exp_vec()) begin fails++; $display("FAIL random[%0d]: got %h want %h", c, act_vec(), exp_vec()); end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_age_order();
        test_ready_override();
        test_full_free();
        test_stall();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Oldest-first issue scheduler that shares the single ALU between the RS_SIZE reservation-station entries. It tracks which RS slots are occupied and their relative age in an age matrix. Each cycle it selects the oldest entry whose operands are ready and registers a one-hot grant. The reservation station uses that grant to drive the ALU operand/opcode inputs on the following cycle.

## Interface
- RS_SIZE, 16: number of reservation-station entries arbitrated
- IDX_W, 4: index width, log2(RS_SIZE)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- rdy  in  1  global ready; low freezes all state and outputs
- clr  in  1  synchronous flush on misprediction
- alloc_enable  in  1  RS writes a new entry this cycle
- alloc_idx  in  IDX_W  slot being written; must currently be free
- ready_vec  in  RS_SIZE  bit i = entry i has both operands ready
- issue_allow  in  1  ALU may accept an instruction next cycle
- issue_enable  out  1  registered: grant valid this cycle
- issue_idx  out  IDX_W  registered: granted entry index
- issue_grant  out  RS_SIZE  registered: one-hot of issue_idx; 0 when issue_enable=0
- occupied_vec  out  RS_SIZE  registered valid bits
- free_idx  out  IDX_W  combinational: lowest index with occupied=0; 0 when full
- full  out  1  combinational: all entries occupied

## Operation
- State:
  - valid[RS_SIZE]
  - age matrix older[i][j] (1 = entry i allocated before entry j), RS_SIZE×RS_SIZE bits
- Candidates: cand[i] = valid[i] & ready_vec[i]; ready_vec bits of invalid entries are ignored.
- Winner: the unique w with cand[w]=1 and no j≠w having cand[j]&older[j][w].
- Issue: when issue_allow=1 and any cand, on the clock edge:
  - issue_enable<=1, issue_idx<=w, issue_grant<=1<<w
  - valid[w]<=0
- No issue: when there is no cand or issue_allow=0, issue_enable<=0, issue_grant<=0, and issue_idx holds.
- Allocate k (alloc_enable=1):
  - valid[k]<=1
  - older[k][j]<=0 for all j
  - older[j][k]<=valid[j] for all j≠k (every resident entry is older)
- Same-cycle alloc and issue: both applied. The issued entry's older[w][k] bit may be set; this is harmless because valid[w]=0.
- Alloc to an occupied slot is illegal; the behaviour is undefined and checked by a bench assertion.
- Priority per edge: rst > clr > !rdy > normal.
  - clr: valid<=0, older<=0, issue_enable<=0, issue_grant<=0, issue_idx<=0. Alloc in the same cycle is dropped.
  - !rdy: every register holds, including issue_enable.
- Reset: every output and register is 0.

## Timing
- Select-to-grant latency is 1 cycle: an entry that is a candidate in cycle t has issue_enable=1 in cycle t+1.
- The entry is cleared at the same edge, so it is never granted twice.
- Alloc-to-grant latency is 2 cycles minimum. An entry allocated at edge t is first a candidate in cycle t (after the edge) and granted at edge t+1. ready_vec in the alloc cycle itself is ignored.
- Throughput is one grant per cycle; back-to-back grants go in strict age order among ready entries.
- free_idx and full reflect the registered valid bits. An entry granted at edge t becomes free in cycle t.
- Reset is asynchronous: outputs go to 0 immediately on rst falling, with no clock required. Deassertion is synchronized by the integrator.

## Test plan
- Reset mid-run: 3 entries occupied and issue_enable=1, then drive rst=0 between edges. All outputs are 0 immediately; after release, full=0 and free_idx=0.
- Age order:
  - Stimulus: alloc 5, 2, 9 in consecutive cycles, then ready_vec=16'h0224.
  - Required: grants idx 5, 2, 9 on consecutive cycles, with issue_grant=16'h0020, 16'h0004, 16'h0200.
- Readiness overrides age:
  - Stimulus: alloc 3 then 7, with only bit 7 ready.
  - Required: grant 7; then after bit 3 is ready, grant 3. Neither is granted twice.
- Full/free:
  - Stimulus: allocate all 16 in order 0..15.
  - Required: full=1 and free_idx=0. After granting idx 0 alone: full=0, free_idx=0. After idx 4 is also granted: free_idx remains 0.
- Stall and allow:
  - rdy=0 for 3 cycles with a ready entry holds issue_enable and issue_idx unchanged and does not drain the entry.
  - issue_allow=0 gives issue_enable=0 and valid unchanged.
- Flush:
  - Stimulus: assert clr with 4 entries occupied, alloc_enable=1 and a ready candidate.
  - Required next cycle: occupied_vec=0, issue_enable=0, and the alloc is dropped.
